// File: rtl/seg_scan_pkg.sv
// Shared constants for the seg_scan four-digit display driver.
// Glyphs are active-low cathode patterns, bit 0 = segment a ... bit 6 = segment g.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Phase within a digit slot: anti-ghosting gap first, then the digit is lit.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  // Active-low anode pattern that enables only digit idx.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-low seven-segment glyph. Non-BCD codes (A-F) show a dash.
module seg_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Pure lookup; default covers the non-BCD codes.
  always_comb begin
    o_seg = SEG_DASH;
    case (i_nib)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed common-anode display driver.
// One digit per slot of SCAN_DIV cycles; each slot opens with BLANK_CYC cycles
// of all anodes off. Inputs are sampled only at the frame boundary (last cycle
// of digit 3) so a frame never mixes two values.
// Optional blinking of the selected digit: define SEG_SCAN_BLINK_EN.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [1:0]  dot_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_sh_data;
  logic [1:0]    r_sh_sel;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_slot_end;
  logic          w_frame_end;
  phase_e        w_phase;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic          w_hide;

  assign w_slot_end  = (r_cnt == CW'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == 2'(NUM_DIGITS - 1));
  assign w_phase     = (r_cnt < CW'(BLANK_CYC)) ? PH_BLANK : PH_SHOW;

  // Slot counter and digit index; reset aborts the slot and restarts at digit 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Shadow capture once per frame keeps the displayed value tear-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sh_data <= 16'h0000;
      r_sh_sel  <= 2'd0;
    end else if (w_frame_end) begin
      r_sh_data <= data;
      r_sh_sel  <= dot_sel;
    end
  end

  // Select the nibble for the digit currently being scanned.
  always_comb begin
    w_nib = r_sh_data[3:0];
    case (r_idx)
      2'd0: w_nib = r_sh_data[3:0];
      2'd1: w_nib = r_sh_data[7:4];
      2'd2: w_nib = r_sh_data[11:8];
      2'd3: w_nib = r_sh_data[15:12];
      default: w_nib = r_sh_data[3:0];
    endcase
  end

  seg_decode u_decode (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] r_frm;
  logic          r_blink_off;

  // Frame counter; the blink phase flips each time it wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frm       <= '0;
      r_blink_off <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frm == FW'(BLINK_FRAMES - 1)) begin
        r_frm       <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_frm <= r_frm + FW'(1);
      end
    end
  end

  assign w_hide = r_blink_off && (r_idx == r_sh_sel);
`else
  logic w_unused_blink;
  assign w_unused_blink = (BLINK_FRAMES > 0);
  assign w_hide         = 1'b0;
`endif

  // Registered outputs: one cycle behind (cnt, idx).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else if (w_phase == PH_BLANK || w_hide) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= an_select(r_idx);
      r_seg <= w_seg;
      r_dp  <= (r_idx == r_sh_sel) ? 1'b0 : 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan.sv
// Testbench for seg_scan with SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
// Driver pushes hand-computed per-cycle output vectors into exp_q; the monitor
// pops one entry per falling edge and compares. Entry packing:
// {seg_check, an[3:0], seg[6:0], dp}.
module tb_seg_scan;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int BLINK_FRAMES = 2;

`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [1:0]  dot_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  logic [12:0] exp_q[$];
  logic [12:0] e;
  int          n_cmp;
  int          n_bad;

  seg_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .dot_sel (dot_sel),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  // Clock / reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand table of the standard active-low glyphs.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int s);
    case (s)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_blank(input int n);
    repeat (n) exp_q.push_back({1'b1, 4'b1111, 7'h7F, 1'b1});
  endtask

  // Expected outputs for one frame (first n cycles of it).
  task automatic push_frame(input logic [15:0] d, input logic [1:0] sel,
                            input bit hide, input int n);
    int k;
    k = 0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (k < n) begin
          if (c < BLANK_CYC) begin
            exp_q.push_back({1'b1, 4'b1111, 7'h7F, 1'b1});
          end else if (hide && (s == int'(sel))) begin
            exp_q.push_back({1'b0, 4'b1111, 7'h7F, 1'b1});
          end else begin
            exp_q.push_back({1'b1, an_of(s), glyph(d[4*s +: 4]),
                             (s == int'(sel)) ? 1'b0 : 1'b1});
          end
        end
        k++;
      end
    end
  endtask

  // Reset for 3 edges; expects blank during reset and frame 0 showing 0000.
  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_blank(3);
    push_frame(16'h0000, 2'd0, 1'b0, 32);
    tick(2);
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: %0d entries left, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (an !== e[11:8] || dp !== e[0] || (e[12] && seg !== e[7:1])) begin
        n_bad++;
        $display("FAIL out[%0d] @%0t: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b%s",
                 n_cmp, $time, an, seg, dp, e[11:8], e[7:1], e[0],
                 e[12] ? "" : " (seg unchecked)");
      end
    end
  end

  // Stimulus
  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    data    = 16'h0000;
    dot_sel = 2'd0;

    // Reset and steady scan of 1234 with dot on digit 2.
    data    = 16'h1234;
    dot_sel = 2'd2;
    do_reset();
    push_frame(16'h1234, 2'd2, 1'b0, 32);
    wait_drain("scan");

    // Tearing: change data mid-frame 1, visible only from frame 2.
    data    = 16'h1234;
    dot_sel = 2'd2;
    do_reset();
    push_frame(16'h1234, 2'd2, 1'b0, 32);
    push_frame(16'h5678, 2'd2, BLINK, 32);
    tick(43);
    data = 16'h5678;
    wait_drain("tear");

    // Non-BCD nibble shows a dash.
    data    = 16'h00A0;
    dot_sel = 2'd0;
    do_reset();
    push_frame(16'h00A0, 2'd0, 1'b0, 32);
    wait_drain("nonbcd");

    // Reset at cnt=5 of slot 2 in frame 1, then restart at digit 0 with 0000.
    data    = 16'h1234;
    dot_sel = 2'd2;
    do_reset();
    push_frame(16'h1234, 2'd2, 1'b0, 2*SCAN_DIV + 5);
    tick(53);
    do_reset();
    wait_drain("midreset");

`ifdef SEG_SCAN_BLINK_EN
    // Blink: selected digit 1 dark in frames 2-3, lit in 0-1 and 4-5.
    data    = 16'h1234;
    dot_sel = 2'd1;
    do_reset();
    push_frame(16'h1234, 2'd1, 1'b0, 32);
    push_frame(16'h1234, 2'd1, 1'b1, 32);
    push_frame(16'h1234, 2'd1, 1'b1, 32);
    push_frame(16'h1234, 2'd1, 1'b0, 32);
    push_frame(16'h1234, 2'd1, 1'b0, 32);
    wait_drain("blink");
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
